datapath_sequencer: RTL

- Multi-cycle program sequencer for the 16-bit register-file/ALU datapath.
- After `start`, it preloads all registers from instruction memory words 0..NUM_REGS-1, then fetches and issues program words from address NUM_REGS upward.
- It drives the datapath's Instruction, InitSel and DataInit inputs and stops on a halt opcode.
- Single synchronous memory read port.

---
 rtl/datapath_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// Program sequencer for the 16-bit register-file/ALU datapath: preloads the
// register file from instruction memory, then fetches and issues program words until halt.
module datapath_sequencer #(
    parameter int         PC_WIDTH = 8,
    parameter int         NUM_REGS = 16,
    parameter logic [3:0] INIT_OP  = 4'h0,
    parameter logic [3:0] HALT_OP  = 4'hF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_rd,
    input  logic [15:0]         imem_data,
    output logic [15:0]         Instruction,
    output logic                InitSel,
    output logic [15:0]         DataInit,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instr_count,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_RD,
        S_INIT_WR,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0]          LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [PC_WIDTH-1:0] PROG_BASE = PC_WIDTH'(NUM_REGS);
    localparam logic [PC_WIDTH-1:0] PC_MAX    = '1;
    localparam logic [15:0]         HALT_WORD = {HALT_OP, 12'h000};

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [3:0]          idx_reg, idx_next;
    logic [15:0]         count_reg, count_next;
    logic                err_reg, err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            idx_reg   <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        idx_next    = idx_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        imem_addr   = '0;
        imem_rd     = 1'b0;
        Instruction = HALT_WORD;
        InitSel     = 1'b1;
        DataInit    = 16'h0000;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_reg)
            S_IDLE, S_HALT: begin
                done = (state_reg == S_HALT);
                if (start) begin
                    state_next = S_INIT_RD;
                    idx_next   = '0;
                    count_next = '0;
                    err_next   = 1'b0;
                end
            end
            S_INIT_RD: begin
                busy       = 1'b1;
                imem_rd    = 1'b1;
                imem_addr  = PC_WIDTH'(idx_reg);
                state_next = S_INIT_WR;
            end
            S_INIT_WR: begin
                // Register file captures DataInit on the edge that ends this cycle
                busy        = 1'b1;
                Instruction = {INIT_OP, idx_reg, 8'h00};
                InitSel     = 1'b0;
                DataInit    = imem_data;
                if (idx_reg == LAST_IDX) begin
                    state_next = S_FETCH;
                    pc_next    = PROG_BASE;
                end else begin
                    idx_next   = idx_reg + 4'd1;
                    state_next = S_INIT_RD;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (!stall) begin
                    imem_rd    = 1'b1;
                    imem_addr  = pc_reg;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // Stall is not consulted here: an issued word always completes
                busy        = 1'b1;
                Instruction = imem_data;
                if (imem_data[15:12] == HALT_OP) begin
                    state_next = S_HALT;
                end else begin
                    if (count_reg != 16'hFFFF)
                        count_next = count_reg + 16'd1;
                    if (pc_reg == PC_MAX) begin
                        err_next   = 1'b1;
                        state_next = S_HALT;
                    end else begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign pc          = pc_reg;
    assign instr_count = count_reg;
    assign err         = err_reg;

endmodule
